// File: rtl/j_flagreg_if.sv
// Bus bundle for the Jerry flags stage: ALU result side, host flags-register
// side and branch condition lookup, as seen from the ALU/host (master) and the flags stage (slave).
interface j_flagreg_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] alu_res;
  logic             alu_co;
  logic             alu_zero;
  logic             alu_valid;
  logic             flag_upd;
  logic             carry_upd;
  logic             stall;
  logic             flagwr;
  logic             flagrd;
  logic [2:0]       din;
  logic [4:0]       cc;
  logic [2:0]       dout;
  logic [WIDTH-1:0] res_q;
  logic             res_valid;
  logic             z;
  logic             c;
  logic             n;
  logic             cc_true;

  modport master (
    output alu_res, alu_co, alu_zero, alu_valid, flag_upd, carry_upd,
           stall, flagwr, flagrd, din, cc,
    input  dout, res_q, res_valid, z, c, n, cc_true
  );

  modport slave (
    input  alu_res, alu_co, alu_zero, alu_valid, flag_upd, carry_upd,
           stall, flagwr, flagrd, din, cc,
    output dout, res_q, res_valid, z, c, n, cc_true
  );
endinterface

// File: rtl/j_flagreg.sv
// Jerry DSP flags stage: one-cycle result latch, Z/C/N flag register with
// host read/write access, and jump condition-code evaluation.
module j_flagreg #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  j_flagreg_if.slave bus
);

  logic [WIDTH-1:0] res_q_r;
  logic             res_valid_r;
  logic             z_r;
  logic             c_r;
  logic             n_r;
  logic [2:0]       dout_r;
  logic             cc_true_s;
  logic             alu_upd_s;

  // cc[1:0]=11 fails on its own because Z cannot be both 0 and 1.
  function automatic logic eval_cc(input logic [4:0] code, input logic fz,
                                   input logic fc, input logic fn);
    logic t_nz;
    logic t_z;
    logic t_cn;
    t_nz = ~code[0] | ~fz;
    t_z  = ~code[1] | fz;
    t_cn = ~code[2] | (code[4] ? (fn == code[3]) : (fc == code[3]));
    return (code != 5'b11111) & t_nz & t_z & t_cn;
  endfunction

  assign alu_upd_s = ~bus.stall & bus.alu_valid & bus.flag_upd;

  // Result latch: tracks the ALU every unstalled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q_r     <= {WIDTH{1'b0}};
      res_valid_r <= 1'b0;
    end else if (!bus.stall) begin
      res_q_r     <= bus.alu_res;
      res_valid_r <= bus.alu_valid;
    end else begin
      res_q_r     <= res_q_r;
      res_valid_r <= res_valid_r;
    end
  end

  // Flag register: host write is not pipelined, so it ignores stall and beats the ALU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_r <= 1'b0;
      c_r <= 1'b0;
      n_r <= 1'b0;
    end else if (bus.flagwr) begin
      z_r <= bus.din[0];
      c_r <= bus.din[1];
      n_r <= bus.din[2];
    end else if (alu_upd_s) begin
      z_r <= bus.alu_zero;
      n_r <= bus.alu_res[WIDTH-1];
      c_r <= bus.carry_upd ? bus.alu_co : c_r;
    end else begin
      z_r <= z_r;
      c_r <= c_r;
      n_r <= n_r;
    end
  end

  // Readback register: captures the flags as they were before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_r <= 3'b000;
    end else if (bus.flagrd) begin
      dout_r <= {n_r, c_r, z_r};
    end else begin
      dout_r <= dout_r;
    end
  end

  // Condition evaluation from the held flags.
  always_comb begin
    cc_true_s = 1'b0;
    cc_true_s = eval_cc(bus.cc, z_r, c_r, n_r);
  end

  assign bus.res_q     = res_q_r;
  assign bus.res_valid = res_valid_r;
  assign bus.z         = z_r;
  assign bus.c         = c_r;
  assign bus.n         = n_r;
  assign bus.dout      = dout_r;
  assign bus.cc_true   = cc_true_s;

endmodule
